// File: rtl/br_resolve_queue_pkg.sv
// Shared sizing, entry type and FSM state for the branch resolution queue.
// Imported by the queue, its commit scanner and its bus interface.
package br_resolve_queue_pkg;

    localparam int SIMBRF   = 2;
    localparam int SIMBRCOM = 2;
    localparam int DEPTH    = 8;
    localparam int TAGW     = $clog2(DEPTH);
    localparam int KW       = $clog2(SIMBRCOM + 1);
    localparam int CW       = TAGW + 1;

    typedef struct packed {
        logic valid;
        logic resolved;
        logic pred;
        logic taken;
    } br_entry_t;

    typedef enum logic {
        RUN        = 1'b0,
        WAIT_FLUSH = 1'b1
    } br_state_e;

    function automatic logic [CW-1:0] lane_count(input logic [SIMBRF-1:0] req);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < SIMBRF; i++)
            n = n + CW'(req[i]);
        return n;
    endfunction

endpackage

// File: rtl/br_resolve_queue_if.sv
// Fetch/resolve/commit bundle between the front end, the branch unit,
// the resolution queue and pred_cnt.
interface br_resolve_queue_if;
    import br_resolve_queue_pkg::*;

    logic                     flush_;
    logic [SIMBRF-1:0]        alloc_;
    logic [SIMBRF-1:0]        alloc_pred;
    logic [SIMBRF*TAGW-1:0]   alloc_tag;
    logic                     busy;
    logic                     res_;
    logic [TAGW-1:0]          res_tag;
    logic                     res_taken_;
    logic [SIMBRCOM-1:0]      br_commit_;
    logic [SIMBRCOM-1:0]      br_taken_;
    logic [SIMBRCOM-1:0]      br_pred_miss_;
    logic                     miss_pend;

    modport master (
        output flush_, alloc_, alloc_pred, res_, res_tag, res_taken_,
        input  alloc_tag, busy, br_commit_, br_taken_, br_pred_miss_,
               miss_pend
    );

    modport slave (
        input  flush_, alloc_, alloc_pred, res_, res_tag, res_taken_,
        output alloc_tag, busy, br_commit_, br_taken_, br_pred_miss_,
               miss_pend
    );

endinterface

// File: rtl/br_commit_scan.sv
// In-order commit window: counts leading resolved entries from head,
// stopping after the first mispredicted one.
module br_commit_scan
    import br_resolve_queue_pkg::*;
(
    input  logic                     i_en,
    input  br_entry_t [SIMBRCOM-1:0] i_ent,
    output logic [KW-1:0]            o_k,
    output logic [SIMBRCOM-1:0]      o_taken,
    output logic [SIMBRCOM-1:0]      o_miss,
    output logic                     o_hit_miss
);

    logic w_go;

    always_comb begin
        o_k        = '0;
        o_taken    = '0;
        o_miss     = '0;
        o_hit_miss = 1'b0;
        w_go       = i_en;
        for (int i = 0; i < SIMBRCOM; i++) begin
            o_taken[i] = i_ent[i].taken;
            o_miss[i]  = i_ent[i].pred ^ i_ent[i].taken;
            if (w_go && i_ent[i].valid && i_ent[i].resolved) begin
                o_k = o_k + KW'(1);
                if (o_miss[i]) begin
                    o_hit_miss = 1'b1;
                    w_go       = 1'b0;
                end
            end else begin
                w_go = 1'b0;
            end
        end
    end

endmodule

// File: rtl/br_resolve_queue.sv
// In-order branch resolution queue: allocates per fetched branch, takes
// out-of-order resolutions, retires in program order into pred_cnt.
module br_resolve_queue
    import br_resolve_queue_pkg::*;
#(
    parameter bit P_ASSERT = 1'b1
) (
    input  logic              clk,
    input  logic              reset_,
    br_resolve_queue_if.slave bus
);

    br_entry_t [DEPTH-1:0]    r_ent;
    logic [TAGW-1:0]          r_head;
    logic [TAGW-1:0]          r_tail;
    logic [CW-1:0]            r_count;
    br_state_e                r_state;
    logic [SIMBRCOM-1:0]      r_commit_;
    logic [SIMBRCOM-1:0]      r_taken_;
    logic [SIMBRCOM-1:0]      r_miss_;
    logic                     r_miss_pend;

    br_entry_t [SIMBRCOM-1:0] w_scan;
    logic [KW-1:0]            w_k;
    logic [SIMBRCOM-1:0]      w_taken;
    logic [SIMBRCOM-1:0]      w_miss;
    logic                     w_hit_miss;
    logic                     w_busy;
    logic [SIMBRF-1:0]        w_req;
    logic [CW-1:0]            w_nal;

    // Full vs empty is decided by count alone; head==tail is ambiguous.
    assign w_busy = (CW'(DEPTH) - r_count) < CW'(SIMBRF);
    assign w_req  = ~bus.alloc_;
    assign w_nal  = w_busy ? '0 : lane_count(w_req);

    always_comb begin
        for (int i = 0; i < SIMBRCOM; i++)
            w_scan[i] = r_ent[r_head + TAGW'(i)];
    end

    br_commit_scan u_scan (
        .i_en       (r_state == RUN),
        .i_ent      (w_scan),
        .o_k        (w_k),
        .o_taken    (w_taken),
        .o_miss     (w_miss),
        .o_hit_miss (w_hit_miss)
    );

    for (genvar g = 0; g < SIMBRF; g++) begin : g_tag
        assign bus.alloc_tag[g*TAGW +: TAGW] = r_tail + TAGW'(g);
    end

    assign bus.busy          = w_busy;
    assign bus.br_commit_    = r_commit_;
    assign bus.br_taken_     = r_taken_;
    assign bus.br_pred_miss_ = r_miss_;
    assign bus.miss_pend     = r_miss_pend;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            for (int i = 0; i < DEPTH; i++)
                r_ent[i] <= '0;
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_state     <= RUN;
            r_commit_   <= '1;
            r_taken_    <= '1;
            r_miss_     <= '1;
            r_miss_pend <= 1'b0;
        end else if (!bus.flush_) begin
            for (int i = 0; i < DEPTH; i++)
                r_ent[i] <= '0;
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_state     <= RUN;
            r_commit_   <= '1;
            r_taken_    <= '1;
            r_miss_     <= '1;
            r_miss_pend <= 1'b0;
        end else begin
            for (int i = 0; i < SIMBRCOM; i++) begin
                if (KW'(i) < w_k)
                    r_ent[r_head + TAGW'(i)].valid <= 1'b0;
                r_commit_[i] <= !(KW'(i) < w_k);
                r_taken_[i]  <= !((KW'(i) < w_k) && w_taken[i]);
                r_miss_[i]   <= !((KW'(i) < w_k) && w_miss[i]);
            end
            // Allocation targets only free slots, so it never hits a live entry.
            for (int i = 0; i < SIMBRF; i++) begin
                if (CW'(i) < w_nal)
                    r_ent[r_tail + TAGW'(i)] <= '{
                        valid: 1'b1, resolved: 1'b0,
                        pred: bus.alloc_pred[i], taken: 1'b0};
            end
            if (!bus.res_ && r_ent[bus.res_tag].valid) begin
                r_ent[bus.res_tag].resolved <= 1'b1;
                r_ent[bus.res_tag].taken    <= !bus.res_taken_;
            end
            r_head  <= r_head + TAGW'(w_k);
            r_tail  <= r_tail + TAGW'(w_nal);
            r_count <= r_count + w_nal - CW'(w_k);
            if (r_state == RUN && w_hit_miss) begin
                r_state     <= WAIT_FLUSH;
                r_miss_pend <= 1'b1;
            end
        end
    end

    if (P_ASSERT) begin : g_chk
        a_busy_alloc: assert property (@(posedge clk) disable iff (!reset_)
            !(bus.flush_ && w_busy && (|w_req)));
        a_contig: assert property (@(posedge clk) disable iff (!reset_)
            ((w_req + SIMBRF'(1)) & w_req) == '0);
    end

endmodule
